// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv unit.
// The divide sequencer and its helper blocks import this package.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned COUNT_W   = 5;

  // The only signed quotient that cannot be represented: most-negative / -1
  function automatic logic is_div_overflow(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/cla_32.sv
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
// Each group's carry-out is formed from group generate/propagate terms.
module cla_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int unsigned j = 0; j < 8; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+4] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Trial subtract is shifted - divisor via cla_32 (a + ~b + 1).
module div_step (
  input  logic [31:0] rem_in,
  input  logic        dvd_msb,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic        qbit
);

  logic [31:0] shifted;
  logic [31:0] diff;
  logic        no_borrow;

  assign shifted = {rem_in[30:0], dvd_msb};

  cla_32 u_trial_sub (
    .a    (shifted),
    .b    (~divisor),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  // rem_in[31] set means the true 33-bit shifted value already exceeds any divisor
  assign qbit    = rem_in[31] | no_borrow;
  assign rem_out = qbit ? diff : shifted;

endmodule

// File: rtl/make_positive.sv
// Two's-complement magnitude of a 32-bit operand when enabled.
// |0x80000000| wraps to 0x80000000, which is the correct unsigned magnitude.
module make_positive (
  input  logic [31:0] value,
  input  logic        enable,
  output logic [31:0] magnitude,
  output logic        negative
);

  assign negative  = enable & value[31];
  assign magnitude = negative ? (~value + 32'd1) : value;

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle 32-bit signed/unsigned restoring divide controller.
// Latches operands on ctrl_DIV, iterates 32 steps, fixes signs, pulses data_resultRDY.
module div_sequencer
  import multdiv_pkg::*;
#(
  parameter bit SIGNED         = 1'b1,
  parameter bit ABORT_ON_START = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic [31:0] data_remainder,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  div_state_t         state;
  logic [COUNT_W-1:0] count;
  logic [31:0]        dvd;
  logic [31:0]        divisor;
  logic [31:0]        rem;
  logic               neg_quot;
  logic               neg_rem;
  logic               ovf;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] step_rem;
  logic        step_q;
  logic [31:0] quot_negated;
  logic [31:0] rem_negated;
  logic [1:0]  neg_cout_unused;
  logic        accept;

  make_positive u_mag_a (
    .value     (data_operandA),
    .enable    (SIGNED),
    .magnitude (mag_a),
    .negative  (sign_a)
  );

  make_positive u_mag_b (
    .value     (data_operandB),
    .enable    (SIGNED),
    .magnitude (mag_b),
    .negative  (sign_b)
  );

  div_step u_step (
    .rem_in  (rem),
    .dvd_msb (dvd[31]),
    .divisor (divisor),
    .rem_out (step_rem),
    .qbit    (step_q)
  );

  cla_32 u_neg_quot (
    .a    (~dvd),
    .b    ('0),
    .cin  (1'b1),
    .sum  (quot_negated),
    .cout (neg_cout_unused[0])
  );

  cla_32 u_neg_rem (
    .a    (~rem),
    .b    ('0),
    .cin  (1'b1),
    .sum  (rem_negated),
    .cout (neg_cout_unused[1])
  );

  assign accept = ctrl_DIV && ((state == IDLE) || (state == DONE) || ABORT_ON_START);

  // dvd doubles as the quotient register: quotient bits shift in as dividend bits shift out
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      count          <= '0;
      dvd            <= '0;
      divisor        <= '0;
      rem            <= '0;
      neg_quot       <= 1'b0;
      neg_rem        <= 1'b0;
      ovf            <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (accept) begin
        dvd      <= mag_a;
        divisor  <= mag_b;
        rem      <= '0;
        count    <= '0;
        neg_quot <= SIGNED & (sign_a ^ sign_b);
        neg_rem  <= SIGNED & sign_a;
        ovf      <= SIGNED & is_div_overflow(data_operandA, data_operandB);
        if (data_operandB == '0) begin
          state          <= DONE;
          busy           <= 1'b0;
          data_result    <= '0;
          data_remainder <= '0;
          data_exception <= 1'b1;
          data_resultRDY <= 1'b1;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            rem   <= step_rem;
            dvd   <= {dvd[30:0], step_q};
            count <= count + 1'b1;
            if (count == COUNT_W'(DIV_ITERS - 1)) state <= SIGN;
          end
          SIGN: begin
            data_result    <= neg_quot ? quot_negated : dvd;
            data_remainder <= neg_rem ? rem_negated : rem;
            data_exception <= ovf;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: latency, sign handling,
// divide-by-zero, overflow, restart while busy and mid-operation reset.
module tb_div_sequencer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic        busy_seen = 1'b0;

  div_sequencer #(.SIGNED(1'b1), .ABORT_ON_START(1'b1)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (busy === 1'b1) busy_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the edge that samples ctrl_DIV
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
  endtask

  // Latency counts the start cycle as cycle 1; gives up at 60
  task automatic wait_rdy(output int lat);
    lat = 1;
    while (data_resultRDY !== 1'b1 && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_e, input int exp_lat);
    int lat;
    start(a, b);
    wait_rdy(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, data_result, exp_q);
    check({tag, "_remainder"}, data_remainder, exp_r);
    check({tag, "_exception"}, {31'd0, data_exception}, {31'd0, exp_e});
    @(posedge clock);
    #1;
    check({tag, "_rdy_pulse"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, "_result_held"}, data_result, exp_q);
  endtask

  initial begin
    int lat;
    int rdy_cnt;

    #12;
    check("reset_result", data_result, 32'd0);
    check("reset_remainder", data_remainder, 32'd0);
    check("reset_flags", {28'd0, data_exception, data_resultRDY, busy, 1'b0}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(posedge clock);

    run_div("pos_by_pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    run_div("neg_by_pos", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    run_div("pos_by_neg", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
    run_div("neg_by_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 34);
    run_div("zero_dividend", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 34);

    busy_seen = 1'b0;
    run_div("div_by_zero", 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1);
    check("div_by_zero_busy", {31'd0, busy_seen}, 32'd0);

    run_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 34);

    // Restart with 9/3 ten cycles after 100/7 started
    start(32'd100, 32'd7);
    rdy_cnt = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) rdy_cnt++;
    end
    check("restart_busy", {31'd0, busy}, 32'd1);
    start(32'd9, 32'd3);
    wait_rdy(lat);
    check("restart_early_rdy", rdy_cnt, 32'd0);
    check("restart_latency", lat, 32'd34);
    check("restart_result", data_result, 32'd3);
    check("restart_remainder", data_remainder, 32'd0);
    check("restart_exception", {31'd0, data_exception}, 32'd0);

    // Reset in the middle of 100/7
    start(32'd100, 32'd7);
    repeat (14) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check("midreset_result", data_result, 32'd0);
    check("midreset_remainder", data_remainder, 32'd0);
    check("midreset_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) rdy_cnt++;
    end
    check("midreset_no_rdy", rdy_cnt, 32'd0);
    check("midreset_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
